wb_mem_slave: RTL and testbench

WB_MEM_SLAVE -- requirements
Module: wb_mem_slave

---
 rtl/wb_mem_slave_if.sv | 25 ++
 rtl/wb_mem_slave.sv | 112 +++++++++++
 tb/tb_wb_mem_slave.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/wb_mem_slave_if.sv
// Wishbone bus bundle between a master and the wb_mem_slave word memory.
interface wb_mem_slave_if #(
    parameter int unsigned ADDR_W = 10
);
    logic              i_wb_cyc;
    logic              i_wb_stb;
    logic              i_wb_we;
    logic [ADDR_W-1:0] i_wb_adr;
    logic [31:0]       i_wb_dat;
    logic [3:0]        i_wb_sel;
    logic [31:0]       o_wb_dat;
    logic              o_wb_ack;
    logic              o_wb_err;
    logic              o_wb_stall;

    modport slave (
        input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_adr, i_wb_dat, i_wb_sel,
        output o_wb_dat, o_wb_ack, o_wb_err, o_wb_stall
    );

    modport master (
        output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_adr, i_wb_dat, i_wb_sel,
        input  o_wb_dat, o_wb_ack, o_wb_err, o_wb_stall
    );
endinterface

// File: rtl/wb_mem_slave.sv
// Wishbone word memory: single-cycle byte-masked writes, two-cycle reads,
// error pulse for addresses beyond DEPTH, write counter and byte checksum.
module wb_mem_slave #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DEPTH  = 768
) (
    input  logic           i_clk,
    input  logic           i_reset,
    wb_mem_slave_if.slave  wb,
    output logic [15:0]    o_wr_count,
    output logic [7:0]     o_checksum
);
    typedef enum logic [1:0] {IDLE, RD1, RD2} state_t;

    localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];

    state_t       state_q, state_d;
    logic         ack_q, ack_d;
    logic         err_q, err_d;
    logic [15:0]  cnt_q, cnt_d;
    logic [7:0]   csum_q, csum_d;
    logic [31:0]  rdat_q;
    logic [31:0]  mem [DEPTH];

    logic         accept;
    logic         in_range;
    logic         wr_ok;
    logic         rd_ok;
    logic [7:0]   wsum;

    // Sum of the byte lanes enabled by sel in the incoming write data.
    always_comb begin
        wsum = '0;
        for (int unsigned b = 0; b < 4; b++) begin
            if (wb.i_wb_sel[b]) begin
                wsum = wsum + wb.i_wb_dat[8*b +: 8];
            end
        end
    end

    // Next-state, request decode and bus outputs.
    always_comb begin
        state_d  = state_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        cnt_d    = cnt_q;
        csum_d   = csum_q;
        wr_ok    = 1'b0;
        rd_ok    = 1'b0;
        in_range = ({1'b0, wb.i_wb_adr} < DEPTH_L);
        accept   = wb.i_wb_cyc && wb.i_wb_stb && (state_q == IDLE);

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!in_range) begin
                        err_d = 1'b1;
                    end else if (wb.i_wb_we) begin
                        wr_ok  = 1'b1;
                        ack_d  = 1'b1;
                        cnt_d  = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
                        csum_d = csum_q + wsum;
                    end else begin
                        rd_ok   = 1'b1;
                        state_d = RD1;
                    end
                end
            end
            RD1:     state_d = wb.i_wb_cyc ? RD2 : IDLE;
            RD2:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        wb.o_wb_stall = (state_q != IDLE);
        wb.o_wb_ack   = ack_q || (state_q == RD2);
        wb.o_wb_err   = err_q;
        wb.o_wb_dat   = (state_q == RD2) ? rdat_q : '0;
        o_wr_count    = cnt_q;
        o_checksum    = csum_q;
    end

    // Control state, ack/err pulses and statistics registers.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            csum_q  <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            csum_q  <= csum_d;
        end
    end

    // Memory array and its registered read port; contents survive reset.
    always_ff @(posedge i_clk) begin
        if (wr_ok) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (wb.i_wb_sel[b]) begin
                    mem[wb.i_wb_adr][8*b +: 8] <= wb.i_wb_dat[8*b +: 8];
                end
            end
        end
        if (rd_ok) begin
            rdat_q <= mem[wb.i_wb_adr];
        end
    end
endmodule

// File: tb/tb_wb_mem_slave.sv
// Directed bench for wb_mem_slave: write/read latency, byte enables,
// out-of-range error, RD1 abort, reset during RD2, counter saturation.
module tb_wb_mem_slave;
    logic        clk;
    logic        rst_n;
    logic [15:0] wr_count;
    logic [7:0]  checksum;
    int          vectors;
    int          miscompares;

    wb_mem_slave_if #(.ADDR_W(10)) bus ();

    wb_mem_slave #(.ADDR_W(10), .DEPTH(768)) dut (
        .i_clk      (clk),
        .i_reset    (rst_n),
        .wb         (bus),
        .o_wr_count (wr_count),
        .o_checksum (checksum)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic cyc, input logic stb, input logic we,
                       input logic [9:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        bus.i_wb_cyc = cyc;
        bus.i_wb_stb = stb;
        bus.i_wb_we  = we;
        bus.i_wb_adr = adr;
        bus.i_wb_dat = dat;
        bus.i_wb_sel = sel;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        req(0, 0, 0, '0, '0, '0);
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_ack",   32'(bus.o_wb_ack),   32'd0);
        chk("rst_err",   32'(bus.o_wb_err),   32'd0);
        chk("rst_stall", 32'(bus.o_wb_stall), 32'd0);
        chk("rst_dat",   bus.o_wb_dat,        32'd0);
        chk("rst_cnt",   32'(wr_count),       32'd0);
        chk("rst_csum",  32'(checksum),       32'd0);

        // Write adr 5 on the first edge after reset release.
        @(negedge clk);
        rst_n = 1'b1;
        req(1, 1, 1, 10'd5, 32'hA1B2C3D4, 4'hF);
        tick();
        chk("wr1_ack",  32'(bus.o_wb_ack), 32'd1);
        chk("wr1_err",  32'(bus.o_wb_err), 32'd0);
        chk("wr1_dat",  bus.o_wb_dat,      32'd0);
        chk("wr1_cnt",  32'(wr_count),     32'd1);
        // A1+B2+C3+D4 = 0x2EA -> 0xEA
        chk("wr1_csum", 32'(checksum),     32'hEA);

        // Back-to-back read of adr 5.
        req(1, 1, 0, 10'd5, '0, 4'hF);
        tick();
        chk("rd1_rd1_ack",   32'(bus.o_wb_ack),   32'd0);
        chk("rd1_rd1_stall", 32'(bus.o_wb_stall), 32'd1);
        req(1, 0, 0, 10'd5, '0, 4'hF);
        tick();
        chk("rd1_ack",   32'(bus.o_wb_ack),   32'd1);
        chk("rd1_dat",   bus.o_wb_dat,        32'hA1B2C3D4);
        chk("rd1_stall", 32'(bus.o_wb_stall), 32'd1);
        tick();
        chk("rd1_done_ack", 32'(bus.o_wb_ack),   32'd0);
        chk("rd1_done_dat", bus.o_wb_dat,        32'd0);
        chk("rd1_done_stl", 32'(bus.o_wb_stall), 32'd0);

        // Single-byte write into lane 1.
        req(1, 1, 1, 10'd5, 32'h0000EE00, 4'h2);
        tick();
        chk("wr2_ack",  32'(bus.o_wb_ack), 32'd1);
        chk("wr2_cnt",  32'(wr_count),     32'd2);
        // 0xEA + 0xEE = 0x1D8 -> 0xD8
        chk("wr2_csum", 32'(checksum),     32'hD8);
        req(1, 1, 0, 10'd5, '0, 4'hF);
        tick();
        req(1, 0, 0, 10'd5, '0, 4'hF);
        tick();
        chk("rd2_ack", 32'(bus.o_wb_ack), 32'd1);
        chk("rd2_dat", bus.o_wb_dat,      32'hA1B2EED4);
        tick();

        // Last valid word, then the first out-of-range address.
        req(1, 1, 1, 10'd767, 32'h12345678, 4'hF);
        tick();
        chk("wr767_cnt",  32'(wr_count), 32'd3);
        // 0xD8 + (12+34+56+78 = 0x114) -> 0xEC
        chk("wr767_csum", 32'(checksum), 32'hEC);
        req(1, 1, 1, 10'd768, 32'hFFFFFFFF, 4'hF);
        tick();
        chk("oor_err",  32'(bus.o_wb_err), 32'd1);
        chk("oor_ack",  32'(bus.o_wb_ack), 32'd0);
        chk("oor_cnt",  32'(wr_count),     32'd3);
        chk("oor_csum", 32'(checksum),     32'hEC);
        req(0, 0, 0, '0, '0, '0);
        tick();
        chk("oor_err_end", 32'(bus.o_wb_err), 32'd0);
        req(1, 1, 0, 10'd767, '0, 4'hF);
        tick();
        req(1, 0, 0, 10'd767, '0, 4'hF);
        tick();
        chk("rd767_ack", 32'(bus.o_wb_ack), 32'd1);
        chk("rd767_dat", bus.o_wb_dat,      32'h12345678);
        tick();

        // Write whose cycle drops right after acceptance still completes.
        req(1, 1, 1, 10'd6, 32'h01010101, 4'hF);
        tick();
        req(0, 0, 0, '0, '0, '0);
        chk("wrdrop_ack",  32'(bus.o_wb_ack), 32'd1);
        chk("wrdrop_cnt",  32'(wr_count),     32'd4);
        chk("wrdrop_csum", 32'(checksum),     32'hF0);
        tick();

        // Read aborted by dropping cyc in RD1.
        req(1, 1, 0, 10'd5, '0, 4'hF);
        tick();
        chk("abort_rd1_stall", 32'(bus.o_wb_stall), 32'd1);
        req(0, 0, 0, '0, '0, '0);
        tick();
        chk("abort_stall", 32'(bus.o_wb_stall), 32'd0);
        chk("abort_ack0",  32'(bus.o_wb_ack),   32'd0);
        tick();
        chk("abort_ack1",  32'(bus.o_wb_ack),   32'd0);
        tick();
        chk("abort_ack2",  32'(bus.o_wb_ack),   32'd0);

        // Reset pulsed while the read sits in RD2.
        req(1, 1, 0, 10'd767, '0, 4'hF);
        tick();
        req(1, 0, 0, 10'd767, '0, 4'hF);
        tick();
        chk("rstrd_pre_ack", 32'(bus.o_wb_ack), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstrd_ack",   32'(bus.o_wb_ack),   32'd0);
        chk("rstrd_err",   32'(bus.o_wb_err),   32'd0);
        chk("rstrd_stall", 32'(bus.o_wb_stall), 32'd0);
        chk("rstrd_dat",   bus.o_wb_dat,        32'd0);
        chk("rstrd_cnt",   32'(wr_count),       32'd0);
        chk("rstrd_csum",  32'(checksum),       32'd0);
        #2 rst_n = 1'b1;
        tick();
        chk("rstrd_post0", 32'(bus.o_wb_ack), 32'd0);
        tick();
        chk("rstrd_post1", 32'(bus.o_wb_ack), 32'd0);
        tick();
        chk("rstrd_post2", 32'(bus.o_wb_ack), 32'd0);
        req(1, 1, 0, 10'd767, '0, 4'hF);
        tick();
        req(1, 0, 0, 10'd767, '0, 4'hF);
        tick();
        chk("keep767_dat", bus.o_wb_dat, 32'h12345678);
        tick();
        req(1, 1, 0, 10'd6, '0, 4'hF);
        tick();
        req(1, 0, 0, 10'd6, '0, 4'hF);
        tick();
        chk("keep6_dat", bus.o_wb_dat, 32'h01010101);
        tick();

        // 70000 back-to-back writes with no byte lanes enabled.
        req(1, 1, 1, 10'd0, 32'hFFFFFFFF, 4'h0);
        for (int i = 1; i <= 70000; i++) begin
            tick();
            if (i == 1)     chk("sat_cnt1",     32'(wr_count), 32'd1);
            if (i == 65534) chk("sat_cnt_fffe", 32'(wr_count), 32'h0000FFFE);
            if (i == 65535) chk("sat_cnt_ffff", 32'(wr_count), 32'h0000FFFF);
            if (i == 70000) begin
                chk("sat_cnt_end", 32'(wr_count),     32'h0000FFFF);
                chk("sat_csum",    32'(checksum),     32'd0);
                chk("sat_ack",     32'(bus.o_wb_ack), 32'd1);
            end
        end
        req(0, 0, 0, '0, '0, '0);
        tick();
        chk("sat_idle_ack", 32'(bus.o_wb_ack), 32'd0);
        chk("sat_idle_cnt", 32'(wr_count),     32'h0000FFFF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
